// File: rtl/seq_shift_reg.sv
// Multi-cycle shift register: parallel load, then shift by amt one position per clock.
// Optional SEQ_SHIFT_ROTATE_EN: when defined, mode 11 rotates; otherwise it acts as logical.
module seq_shift_reg #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             start,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] amt,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             cout
);

    // Handshake: load and start are accepted only in IDLE. busy stays high while shifting.
    // done is a one-cycle pulse; q and cout hold the result while done is high.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             dir_q;
    logic [1:0]       mode_q;
    logic             fill;
    logic [WIDTH-1:0] shifted;
    logic             out_bit;

    always_comb begin
        fill = 1'b0;
        case (mode_q)
            2'b01:   fill = ser_in;
            2'b10:   fill = dir_q ? 1'b0 : q[WIDTH-1];
`ifdef SEQ_SHIFT_ROTATE_EN
            2'b11:   fill = dir_q ? q[WIDTH-1] : q[0];
`endif
            default: fill = 1'b0;
        endcase
        shifted = dir_q ? {q[WIDTH-2:0], fill} : {fill, q[WIDTH-1:1]};
        out_bit = dir_q ? q[WIDTH-1] : q[0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            q      <= '0;
            cout   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            dir_q  <= 1'b0;
            mode_q <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (load) begin
                        q    <= in;
                        cout <= 1'b0;
                    end else if (start) begin
                        if (amt == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            dir_q  <= dir;
                            mode_q <= mode;
                            cnt    <= (amt > WIDTH_C) ? WIDTH_C : amt;
                            busy   <= 1'b1;
                            state  <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    q    <= shifted;
                    cout <= out_bit;
                    cnt  <= cnt - ONE_C;
                    if (cnt == ONE_C) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_reg.sv
// Bench for seq_shift_reg (WIDTH=8): directed loads/shifts, done-driven scoreboard.
module tb_seq_shift_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             load = 1'b0;
    logic             start = 1'b0;
    logic             dir = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [CNT_W-1:0] amt = '0;
    logic             ser_in = 1'b0;
    logic [WIDTH-1:0] in = '0;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             cout;

    int n_tests = 0;
    int n_fail  = 0;

    // expectation word: {busy cycles[7:0], cout, q[7:0]}
    logic [16:0] exp_q[$];

    seq_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .load(load), .start(start), .dir(dir),
        .mode(mode), .amt(amt), .ser_in(ser_in), .in(in),
        .q(q), .busy(busy), .done(done), .cout(cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: pops an expectation on every done pulse
    int   busy_seen = 0;
    logic last_busy = 1'b0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst) begin
            busy_seen = 0;
            last_busy = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                check("done_width", 64'(prev_done), 64'd0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no done");
                end else begin
                    e = exp_q.pop_front();
                    check("q", 64'(q), 64'(e[7:0]));
                    check("cout", 64'(cout), 64'(e[8]));
                    check("busy_cycles", 64'(busy_seen), 64'(e[16:9]));
                    if (e[16:9] != 0) check("done_after_busy", 64'(last_busy), 64'd1);
                end
                busy_seen = 0;
            end
            if (busy) busy_seen++;
            last_busy = busy;
            prev_done = done;
        end
    end

    task automatic do_load(input logic [WIDTH-1:0] v);
        @(negedge clk);
        load = 1'b1;
        in   = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic do_start(input logic d, input logic [1:0] m, input logic [CNT_W-1:0] a,
                            input logic [7:0] ser_bits, input bit noise,
                            input logic [7:0] eq, input logic ec, input logic [7:0] en);
        bit seen;
        seen = 0;
        @(negedge clk);
        start = 1'b1;
        dir   = d;
        mode  = m;
        amt   = a;
        ser_in = 1'b0;
        exp_q.push_back({en, ec, eq});
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start = 1'b0;
                if (a == 0) check("amt0_done_next_cycle", 64'(done), 64'd1);
                if (noise) begin
                    load = 1'b1;
                    in   = 8'hFF;
                    dir  = ~d;
                    mode = ~m;
                    amt  = '0;
                end
            end
            if (i == 1) load = 1'b0;
            ser_in = (i < 8) ? ser_bits[i] : 1'b0;
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] rot_l_q;
        logic [7:0] rot_r_q;
`ifdef SEQ_SHIFT_ROTATE_EN
        rot_l_q = 8'h03;
        rot_r_q = 8'h80;
`else
        rot_l_q = 8'h02;
        rot_r_q = 8'h00;
`endif
        repeat (3) @(negedge clk);
        check("rst_q", 64'(q), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        rst = 1'b1;

        do_load(8'hB4);
        do_start(1'b0, 2'b00, 4'd3, 8'h00, 1'b1, 8'h16, 1'b1, 8'd3);
        do_load(8'h81);
        do_start(1'b0, 2'b10, 4'd2, 8'h00, 1'b0, 8'hE0, 1'b0, 8'd2);
        do_load(8'h81);
        do_start(1'b1, 2'b11, 4'd1, 8'h00, 1'b0, rot_l_q, 1'b1, 8'd1);
        do_load(8'h01);
        do_start(1'b0, 2'b11, 4'd1, 8'h00, 1'b0, rot_r_q, 1'b1, 8'd1);
        do_load(8'h81);
        do_start(1'b1, 2'b10, 4'd1, 8'h00, 1'b0, 8'h02, 1'b1, 8'd1);
        do_load(8'h00);
        do_start(1'b1, 2'b01, 4'd4, 8'b0000_1101, 1'b0, 8'h0B, 1'b0, 8'd4);
        do_start(1'b0, 2'b00, 4'd0, 8'h00, 1'b0, 8'h0B, 1'b0, 8'd0);
        do_load(8'hFF);
        do_start(1'b0, 2'b00, 4'd12, 8'h00, 1'b0, 8'h00, 1'b1, 8'd8);

        // load and start together: only the load lands
        @(negedge clk);
        load = 1'b1; start = 1'b1; in = 8'h5A; dir = 1'b0; mode = 2'b00; amt = 4'd3;
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        check("load_start_q", 64'(q), 64'h5A);
        check("load_start_busy", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        check("load_start_q_hold", 64'(q), 64'h5A);

        // reset in the second shift cycle
        do_load(8'hFF);
        @(negedge clk);
        start = 1'b1; dir = 1'b0; mode = 2'b00; amt = 4'd5;
        @(negedge clk);
        start = 1'b0;
        check("mid_shift_busy", 64'(busy), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_q", 64'(q), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_cout", 64'(cout), 64'd0);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        check("post_rst_q", 64'(q), 64'd0);
        check("pending_expect", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
